// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package if_fetch_pkg;

  localparam int INST_W      = 32;
  localparam int INST_ADDR_W = 32;
  localparam int IF_STATE_W  = 2;

  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [IF_STATE_W-1:0] S_FETCH = 2'd0;
  localparam logic [IF_STATE_W-1:0] S_WAIT  = 2'd1;
  localparam logic [IF_STATE_W-1:0] S_DROP  = 2'd2;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] addr;
    logic [INST_W-1:0]      data;
  } fetch_entry_t;

  localparam int ENTRY_W = INST_ADDR_W + INST_W;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-unit bus bundle: instruction memory side, decode side and redirect input.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                   imem_req_o;
  logic [INST_ADDR_W-1:0] imem_addr_o;
  logic                   imem_ack_i;
  logic [INST_W-1:0]      imem_data_i;
  logic [INST_W-1:0]      inst_o;
  logic [INST_ADDR_W-1:0] inst_addr_o;
  logic                   inst_valid_o;
  logic                   inst_ready_i;
  logic                   redirect_i;
  logic [INST_ADDR_W-1:0] redirect_addr_i;

  modport master (
    output imem_req_o, imem_addr_o, inst_o, inst_addr_o, inst_valid_o,
    input  imem_ack_i, imem_data_i, inst_ready_i, redirect_i, redirect_addr_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, inst_o, inst_addr_o, inst_valid_o,
    output imem_ack_i, imem_data_i, inst_ready_i, redirect_i, redirect_addr_i
  );

endinterface

// File: rtl/if_fetch_fifo.sv
// if_fifo: small synchronous FIFO with single-cycle flush and occupancy count.
module if_fifo #(
  parameter int FIFO_DEPTH = 2,
  parameter int WIDTH      = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch unit: PC owner, single-outstanding imem requests, buffered hand-off to decode.
// Optional macro IF_MISALIGN_EXC_EN adds fetch_misalign_o and blocks fetch on misaligned redirects.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_ADDR = 32'h0000_0000,
  parameter int                     FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  if_fetch_if.master  bus
`ifdef IF_MISALIGN_EXC_EN
  ,
  output logic        fetch_misalign_o
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [IF_STATE_W-1:0]  state;
  logic [INST_ADDR_W-1:0] pc;
  logic [INST_ADDR_W-1:0] req_addr;
  logic                   req;
  logic                   misalign;
  logic [CNT_W-1:0]       count;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   can_issue;
  logic [INST_ADDR_W-1:0] redirect_pc;
  logic                   redirect_bad;
  fetch_entry_t           head;
  fetch_entry_t           push_entry;

`ifdef IF_MISALIGN_EXC_EN
  assign redirect_pc      = bus.redirect_addr_i;
  assign redirect_bad     = |bus.redirect_addr_i[1:0];
  assign fetch_misalign_o = misalign;
`else
  assign redirect_pc      = {bus.redirect_addr_i[INST_ADDR_W-1:2], 2'b00};
  assign redirect_bad     = 1'b0;
`endif

  // Nothing is outstanding in S_FETCH, so occupancy alone proves a free slot at ack time.
  assign can_issue  = (count < DEPTH_C) && !misalign;
  assign push       = (state == S_WAIT) && bus.imem_ack_i && !bus.redirect_i;
  assign pop        = !empty && bus.inst_ready_i;
  assign push_entry = '{addr: pc, data: bus.imem_data_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= RESET_ADDR;
      req      <= 1'b0;
      req_addr <= RESET_ADDR;
      misalign <= 1'b0;
    end else if (bus.redirect_i) begin
      pc       <= redirect_pc;
      misalign <= redirect_bad;
      if (state != S_FETCH) begin
        if (bus.imem_ack_i) begin
          req   <= 1'b0;
          state <= S_FETCH;
        end else begin
          state <= S_DROP;
        end
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (can_issue) begin
            req      <= 1'b1;
            req_addr <= pc;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_ack_i) begin
            pc    <= pc + 32'd4;
            req   <= 1'b0;
            state <= S_FETCH;
          end
        end
        S_DROP: begin
          if (bus.imem_ack_i) begin
            req   <= 1'b0;
            state <= S_FETCH;
          end
        end
        default: begin
          req   <= 1'b0;
          state <= S_FETCH;
        end
      endcase
    end
  end

  if_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  assign bus.imem_req_o   = req;
  assign bus.imem_addr_o  = req_addr;
  assign bus.inst_valid_o = !empty;
  assign bus.inst_o       = empty ? INST_NOP : head.data;
  assign bus.inst_addr_o  = empty ? pc : head.addr;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized and directed bench for if_fetch against a queue-based fetch/deliver model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_addr = '0;
  logic        mem_ack = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_rand = 1'b0;
  int          lat = 1;
  int          wcnt = 0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  // model state
  logic [31:0] q[$];
  logic [31:0] fetch_pc;
  logic        out_busy;
  logic        stale;
  logic [31:0] out_addr;
  logic        mflag;
  logic [31:0] deliv[$];
  logic [31:0] reqs[$];
  int          dcyc[$];

  always #5 clk = ~clk;

  if_fetch_if bus();
  assign bus.imem_ack_i      = mem_ack | stray;
  assign bus.imem_data_i     = stray ? 32'hDEAD_BEEF : mem_data;
  assign bus.inst_ready_i    = ready;
  assign bus.redirect_i      = redir;
  assign bus.redirect_addr_i = redir_addr;

`ifdef IF_MISALIGN_EXC_EN
  logic misalign_o;
  if_fetch #(.RESET_ADDR(RST_A), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .fetch_misalign_o(misalign_o));
`else
  if_fetch #(.RESET_ADDR(RST_A), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory: acks in the lat-th cycle a request is seen, one ack per request.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt = 0;
      if (mem_rand) lat = $urandom_range(1, 4);
    end else if (bus.imem_req_o) begin
      if (wcnt >= lat - 1) begin
        mem_ack = 1'b1;
        mem_data = word(bus.imem_addr_o);
      end else begin
        wcnt++;
      end
    end
  end

  // Compare process: check outputs against the model, then advance the model for the next edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk1("rst_req", bus.imem_req_o, 1'b0);
      chk("rst_imem_addr", bus.imem_addr_o, RST_A);
      chk1("rst_valid", bus.inst_valid_o, 1'b0);
      chk("rst_inst", bus.inst_o, INST_NOP);
      chk("rst_inst_addr", bus.inst_addr_o, RST_A);
`ifdef IF_MISALIGN_EXC_EN
      chk1("rst_misalign", misalign_o, 1'b0);
`endif
      q.delete();
      fetch_pc = RST_A;
      out_busy = 1'b0;
      stale = 1'b0;
      out_addr = RST_A;
      mflag = 1'b0;
    end else begin
      chk1("valid", bus.inst_valid_o, q.size() != 0);
      if (q.size() != 0) begin
        chk("inst_addr", bus.inst_addr_o, q[0]);
        chk("inst", bus.inst_o, word(q[0]));
      end else begin
        chk("nop", bus.inst_o, INST_NOP);
      end
`ifdef IF_MISALIGN_EXC_EN
      chk1("misalign", misalign_o, mflag);
`endif
      if (out_busy) begin
        chk1("req_hold", bus.imem_req_o, 1'b1);
        chk("req_addr_hold", bus.imem_addr_o, out_addr);
      end else if (bus.imem_req_o) begin
        chk("req_addr", bus.imem_addr_o, fetch_pc);
        chk1("credit", q.size() < DEPTH, 1'b1);
        chk1("req_blocked", mflag, 1'b0);
        out_busy = 1'b1;
        stale = 1'b0;
        out_addr = bus.imem_addr_o;
        reqs.push_back(bus.imem_addr_o);
      end
      if (bus.inst_valid_o && ready) begin
        deliv.push_back(bus.inst_addr_o);
        dcyc.push_back(cyc);
        if (q.size() != 0) void'(q.pop_front());
      end
      if (redir) begin
        q.delete();
`ifdef IF_MISALIGN_EXC_EN
        fetch_pc = redir_addr;
        mflag = |redir_addr[1:0];
`else
        fetch_pc = {redir_addr[31:2], 2'b00};
`endif
        if (out_busy) begin
          if (bus.imem_ack_i) begin
            out_busy = 1'b0;
            stale = 1'b0;
          end else begin
            stale = 1'b1;
          end
        end
      end else if (out_busy && bus.imem_ack_i) begin
        if (!stale) begin
          q.push_back(out_addr);
          fetch_pc = out_addr + 32'd4;
        end
        out_busy = 1'b0;
        stale = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int l);
    mem_rand = 1'b0;
    lat = l;
    redir = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    deliv.delete();
    reqs.delete();
    dcyc.delete();
  endtask

  task automatic wait_deliv(input int n);
    int k = 0;
    while (deliv.size() < n && k < 300) begin
      step();
      k++;
    end
    chk1("deliv_wait", deliv.size() >= n, 1'b1);
  endtask

  task automatic wait_reqs(input int n);
    int k = 0;
    while (reqs.size() < n && k < 300) begin
      step();
      k++;
    end
    chk1("req_wait", reqs.size() >= n, 1'b1);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redir_addr = a;
    redir = 1'b1;
    step();
    redir = 1'b0;
    deliv.delete();
    dcyc.delete();
    reqs.delete();
  endtask

  initial begin
    int c0;
    int k;
    #1 rst = 1'b1;

    // Streaming with single-cycle memory: 0,4,8,12 at one every two cycles.
    ready = 1'b1;
    do_reset(1);
    c0 = cyc;
    wait_deliv(4);
    chk("seq0", deliv[0], 32'h0);
    chk("seq1", deliv[1], 32'h4);
    chk("seq2", deliv[2], 32'h8);
    chk("seq3", deliv[3], 32'hC);
    chk("first_latency", 32'(dcyc[0] - c0), 32'd3);
    for (int i = 0; i < 3; i++) chk("spacing", 32'(dcyc[i+1] - dcyc[i]), 32'd2);

    // Decode stall: buffer fills to two, requests stop, then drains in order.
    ready = 1'b0;
    do_reset(1);
    repeat (10) step();
    chk1("stall_req_off", bus.imem_req_o, 1'b0);
    chk("stall_reqs", 32'(reqs.size()), 32'd2);
    chk("stall_head", bus.inst_addr_o, 32'h0);
    ready = 1'b1;
    wait_deliv(3);
    chk("drain0", deliv[0], 32'h0);
    chk("drain1", deliv[1], 32'h4);
    chk("drain2", deliv[2], 32'h8);

    // Redirect one cycle after a slow request: stale ack dropped.
    do_reset(3);
    wait_reqs(1);
    redir_addr = 32'h100;
    redir = 1'b1;
    step();
    redir = 1'b0;
    wait_reqs(2);
    chk("drop_req", reqs[1], 32'h100);
    wait_deliv(1);
    chk("drop_first", deliv[0], 32'h100);

    // Redirect in the same cycle as the ack.
    do_reset(2);
    k = 0;
    while (!mem_ack && k < 20) begin
      step();
      k++;
    end
    chk1("ack_seen", mem_ack, 1'b1);
    redirect_to(32'h200);
    chk1("same_ack_empty", bus.inst_valid_o, 1'b0);
    wait_reqs(1);
    chk("same_ack_req", reqs[0], 32'h200);
    wait_deliv(1);
    chk("same_ack_first", deliv[0], 32'h200);

    // Asynchronous reset with a request outstanding, then a stray ack.
    do_reset(3);
    wait_reqs(1);
    rst = 1'b1;
    #1;
    chk1("arst_req", bus.imem_req_o, 1'b0);
    chk("arst_addr", bus.imem_addr_o, RST_A);
    chk1("arst_valid", bus.inst_valid_o, 1'b0);
    chk("arst_inst", bus.inst_o, INST_NOP);
    step();
    step();
    rst = 1'b0;
    stray = 1'b1;
    deliv.delete();
    reqs.delete();
    step();
    stray = 1'b0;
    wait_deliv(1);
    chk("arst_restart", deliv[0], RST_A);
    chk("arst_req0", reqs[0], RST_A);

    // Misaligned redirect target.
    do_reset(1);
    repeat (5) step();
    redirect_to(32'h102);
`ifdef IF_MISALIGN_EXC_EN
    repeat (6) step();
    chk1("mis_flag", misalign_o, 1'b1);
    chk("mis_noreq", 32'(reqs.size()), 32'd0);
    redirect_to(32'h104);
    wait_deliv(1);
    chk("mis_resume", deliv[0], 32'h104);
    chk1("mis_clear", misalign_o, 1'b0);
`else
    wait_reqs(1);
    chk("align_req", reqs[0], 32'h100);
    wait_deliv(1);
    chk("align_first", deliv[0], 32'h100);
`endif

    // PC wrap.
    repeat (3) step();
    redirect_to(32'hFFFF_FFF8);
    wait_deliv(3);
    chk("wrap0", deliv[0], 32'hFFFF_FFF8);
    chk("wrap1", deliv[1], 32'hFFFF_FFFC);
    chk("wrap2", deliv[2], 32'h0000_0000);

    // Random traffic: latency, stalls and redirects.
    mem_rand = 1'b1;
    deliv.delete();
    for (int i = 0; i < 1500; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        redir = 1'b1;
`ifdef IF_MISALIGN_EXC_EN
        redir_addr = ($urandom & 32'h0000_0FFC) | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
`else
        redir_addr = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(0, 3));
`endif
      end else begin
        redir = 1'b0;
      end
      step();
    end
    redir = 1'b0;
    ready = 1'b1;
    repeat (10) step();
    chk1("rand_progress", deliv.size() > 50, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
